// File: rtl/audio_tick_master.sv
// Avalon-MM master that runs the interval timer and turns each acknowledged timeout into a tick strobe.
// Optional read-verify of the status register before clearing: AUDIO_TICK_STATUS_READ_EN.
module audio_tick_master #(
    parameter logic [3:0]  CTRL_START = 4'h7,
    parameter logic [3:0]  CTRL_STOP  = 4'h8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [2:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [15:0]      writedata,
    input  logic [15:0]      readdata,
    input  logic             irq,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             running,
    output logic             error
);

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WAIT_IRQ,
        S_RD_ADDR,
        S_RD_DATA,
        S_CLR,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_cs;
    logic                w_wn;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_tick;
    logic                w_set_error;
    logic                w_unused_rd;

    // Only bit 0 (TO) of the status word matters; the rest is deliberately ignored.
    assign w_unused_rd = ^readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, then bus/strobe values for the state being entered so they register with it.
    always_comb begin
        w_next_state = r_state;
        w_cs         = 1'b0;
        w_wn         = 1'b1;
        w_addr       = ADDR_STATUS;
        w_wdata      = '0;
        w_tick       = 1'b0;
        w_set_error  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next_state = S_CFG;
                end
            end
            S_CFG: w_next_state = S_WAIT_IRQ;
            S_WAIT_IRQ: begin
                if (irq) begin
`ifdef AUDIO_TICK_STATUS_READ_EN
                    w_next_state = S_RD_ADDR;
`else
                    w_next_state = S_CLR;
`endif
                end else if (!enable) begin
                    w_next_state = S_STOP;
                end
            end
`ifdef AUDIO_TICK_STATUS_READ_EN
            S_RD_ADDR: w_next_state = S_RD_DATA;
            S_RD_DATA: begin
                if (readdata[0]) begin
                    w_next_state = S_CLR;
                end else begin
                    w_next_state = S_WAIT_IRQ;
                    w_set_error  = 1'b1;
                end
            end
`endif
            S_CLR:   w_next_state = S_WAIT_IRQ;
            S_STOP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        case (w_next_state)
            S_CFG: begin
                w_cs    = 1'b1;
                w_wn    = 1'b0;
                w_addr  = ADDR_CONTROL;
                w_wdata = DATA_W'(CTRL_START);
            end
`ifdef AUDIO_TICK_STATUS_READ_EN
            S_RD_ADDR: begin
                w_cs = 1'b1;
            end
`endif
            S_CLR: begin
                w_cs   = 1'b1;
                w_wn   = 1'b0;
                w_tick = 1'b1;
            end
            S_STOP: begin
                w_cs    = 1'b1;
                w_wn    = 1'b0;
                w_addr  = ADDR_CONTROL;
                w_wdata = DATA_W'(CTRL_STOP);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address    <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
            running    <= 1'b0;
            error      <= 1'b0;
        end else begin
            address    <= w_addr;
            chipselect <= w_cs;
            write_n    <= w_wn;
            writedata  <= w_wdata;
            tick       <= w_tick;
            running    <= (w_next_state != S_IDLE);
            if (w_tick) begin
                tick_count <= tick_count + CNT_W'(1);
            end
`ifdef AUDIO_TICK_STATUS_READ_EN
            error      <= error | w_set_error;
`else
            error      <= w_set_error;
`endif
        end
    end

endmodule

// File: tb/tb_audio_tick_master.sv
// Bench for audio_tick_master: directed vector table, randomized timeout traffic against a
// transaction-level model, counter wrap on a narrow-counter instance, and async reset mid-clear.
module tb_audio_tick_master;

`ifdef AUDIO_TICK_STATUS_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif
    localparam int LAT = READ_EN ? 3 : 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] readdata;
    logic        irq;

    logic [2:0]  address,    address4;
    logic        chipselect, chipselect4;
    logic        write_n,    write_n4;
    logic [15:0] writedata,  writedata4;
    logic        tick,       tick4;
    logic [15:0] tick_count;
    logic [3:0]  tick_count4;
    logic        running,    running4;
    logic        error,      error4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    audio_tick_master u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq),
        .tick(tick), .tick_count(tick_count), .running(running), .error(error)
    );

    audio_tick_master #(.CNT_W(4)) u_dut_w4 (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .address(address4), .chipselect(chipselect4), .write_n(write_n4), .writedata(writedata4),
        .readdata(readdata), .irq(irq),
        .tick(tick4), .tick_count(tick_count4), .running(running4), .error(error4)
    );

    typedef struct {
        logic        en;
        logic        irq;
        logic [15:0] rd;
        logic [23:0] exp;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] mk(logic cs, logic wn, logic [2:0] a, logic [15:0] wd,
                                       logic tk, logic run, logic err);
        return {cs, wn, a, wd, tk, run, err};
    endfunction

    function automatic logic [23:0] b_idle(logic run, logic err); return mk(1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, run, err); endfunction
    function automatic logic [23:0] b_cfg(logic err);  return mk(1'b1, 1'b0, 3'd1, 16'h0007, 1'b0, 1'b1, err); endfunction
    function automatic logic [23:0] b_stop(logic err); return mk(1'b1, 1'b0, 3'd1, 16'h0008, 1'b0, 1'b1, err); endfunction
    function automatic logic [23:0] b_rd(logic err);   return mk(1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b1, err); endfunction
    function automatic logic [23:0] b_clr(logic err);  return mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, err); endfunction

    function automatic logic [23:0] snap();
        return {chipselect, write_n, address, writedata, tick, running, error};
    endfunction

    function automatic logic [23:0] snap4();
        return {chipselect4, write_n4, address4, writedata4, tick4, running4, error4};
    endfunction

    function automatic vec_t v(logic en, logic irq_v, logic [15:0] rd, logic [23:0] exp, int cnt);
        vec_t r;
        r.en = en; r.irq = irq_v; r.rd = rd; r.exp = exp; r.cnt = cnt;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string nm, input logic [23:0] exp, input int cnt);
        check({nm, " bus"},  32'(snap()),      32'(exp));
        check({nm, " bus4"}, 32'(snap4()),     32'(exp));
        check({nm, " cnt"},  32'(tick_count),  32'(cnt & 32'hFFFF));
        check({nm, " cnt4"}, 32'(tick_count4), 32'(cnt & 32'hF));
    endtask

    // Drive inputs for one cycle and check the outputs registered at its closing edge.
    task automatic step(input string nm, input logic en, input logic irq_v, input logic [15:0] rd,
                        input logic [23:0] exp, input int cnt);
        enable   = en;
        irq      = irq_v;
        readdata = rd;
        @(posedge clk);
        #1;
        check_all(nm, exp, cnt);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic        err;
        logic [15:0] st;
        logic        ok;
        logic [23:0] e;
        logic        en_r;

        reset_n  = 1'b0;
        enable   = 1'b0;
        irq      = 1'b0;
        readdata = 16'h0000;
        #12;
        check_all("reset", b_idle(1'b0, 1'b0), 0);

`ifdef AUDIO_TICK_STATUS_READ_EN
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_idle(1'b0, 1'b0), 0));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_cfg(1'b0), 0));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 0));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 0));
        tbl.push_back(v(1'b1, 1'b1, 16'h0003, b_rd(1'b0), 0));
        tbl.push_back(v(1'b1, 1'b1, 16'h0003, b_idle(1'b1, 1'b0), 0));
        tbl.push_back(v(1'b1, 1'b1, 16'h0003, b_clr(1'b0), 1));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 1));
        tbl.push_back(v(1'b1, 1'b1, 16'h0002, b_rd(1'b0), 1));
        tbl.push_back(v(1'b1, 1'b0, 16'h0002, b_idle(1'b1, 1'b0), 1));
        tbl.push_back(v(1'b1, 1'b0, 16'h0002, b_idle(1'b1, 1'b1), 1));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_stop(1'b1), 1));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_idle(1'b0, 1'b1), 1));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_cfg(1'b1), 1));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b1), 1));
        tbl.push_back(v(1'b0, 1'b1, 16'h0001, b_rd(1'b1), 1));
        tbl.push_back(v(1'b0, 1'b1, 16'h0001, b_idle(1'b1, 1'b1), 1));
        tbl.push_back(v(1'b0, 1'b1, 16'h0001, b_clr(1'b1), 2));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_idle(1'b1, 1'b1), 2));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_stop(1'b1), 2));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_idle(1'b0, 1'b1), 2));
        cnt = 2;
        err = 1'b1;
`else
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_idle(1'b0, 1'b0), 0));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_cfg(1'b0), 0));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 0));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 0));
        tbl.push_back(v(1'b1, 1'b1, 16'h0003, b_clr(1'b0), 1));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 1));
        tbl.push_back(v(1'b1, 1'b1, 16'h0002, b_clr(1'b0), 2));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 2));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_stop(1'b0), 2));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_idle(1'b0, 1'b0), 2));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_cfg(1'b0), 2));
        tbl.push_back(v(1'b1, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 2));
        tbl.push_back(v(1'b0, 1'b1, 16'h0000, b_clr(1'b0), 3));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_idle(1'b1, 1'b0), 3));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_stop(1'b0), 3));
        tbl.push_back(v(1'b0, 1'b0, 16'h0000, b_idle(1'b0, 1'b0), 3));
        cnt = 3;
        err = 1'b0;
`endif

        @(negedge clk);
        reset_n = 1'b1;
        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].en, tbl[i].irq, tbl[i].rd, tbl[i].exp, tbl[i].cnt);
        end

        // Random timeouts: every event is read (optional), verified, cleared and counted.
        step("r_cfg",  1'b1, 1'b0, 16'h0000, b_cfg(err), cnt);
        step("r_wait", 1'b1, 1'b0, 16'h0000, b_idle(1'b1, err), cnt);
        for (int ev = 0; ev < 150; ev++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                step("r_gap", 1'b1, 1'b0, 16'($urandom), b_idle(1'b1, err), cnt);
            end
            st = 16'($urandom);
            ok = READ_EN ? st[0] : 1'b1;
            for (int k = 1; k <= LAT + 1; k++) begin
                en_r = (k == LAT + 1 && !ok) ? 1'b1 : 1'($urandom);
                if (READ_EN && k == 1) begin
                    e = b_rd(err);
                end else if (k == LAT && ok) begin
                    cnt++;
                    e = b_clr(err);
                end else begin
                    if (k == LAT) err = 1'b1;
                    e = b_idle(1'b1, err);
                end
                step($sformatf("r_ev%0d_k%0d", ev, k), en_r, (k == 1) || ok, st, e, cnt);
            end
            if ($urandom_range(0, 5) == 0) begin
                step("r_stop",    1'b0, 1'b0, 16'h0000, b_stop(err), cnt);
                step("r_idle",    1'b0, 1'b0, 16'h0000, b_idle(1'b0, err), cnt);
                step("r_recfg",   1'b1, 1'b0, 16'h0000, b_cfg(err), cnt);
                step("r_rewait",  1'b1, 1'b0, 16'h0000, b_idle(1'b1, err), cnt);
            end
        end

        // Async reset in the middle of the clear write.
        for (int k = 1; k <= LAT; k++) begin
            if (k == LAT) begin
                cnt++;
                e = b_clr(err);
            end else begin
                e = (k == 1) ? b_rd(err) : b_idle(1'b1, err);
            end
            step("pre_rst", 1'b1, 1'b1, 16'h0001, e, cnt);
        end
        irq = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_all("rst_mid_clr", b_idle(1'b0, 1'b0), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step("post_rst", 1'b0, 1'b0, 16'h0000, b_idle(1'b0, 1'b0), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/audio_tick_master.md
# audio_tick_master

Avalon-MM master that drives the 16-bit interval-timer slave (3-bit word address, registered readdata, level irq) without CPU involvement. On enable it programs the timer for continuous interrupting operation. On each timer interrupt it confirms the status, acknowledges it and emits a one-cycle `tick` pulse plus a running tick count. It sits beside the timer in the AGC subsystem and supplies the audio frame/block-rate strobe directly to datapath logic.

## Interface
- CTRL_START, default 4'h7: control word written at start (bit2 START, bit1 CONT, bit0 ITO).
- CTRL_STOP, default 4'h8: control word written at stop (bit3 STOP).
- CNT_W, default 16: width of `tick_count`.

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  level; high runs the timer, low stops it
- address  out  3  word address to timer slave
- chipselect  out  1  slave select
- write_n  out  1  active-low write
- writedata  out  16  write data; upper 12 bits always 0
- readdata  in  16  slave read data, valid the cycle after address/chipselect are presented
- irq  in  1  timer interrupt, level
- tick  out  1  one-cycle pulse per acknowledged timeout
- tick_count  out  CNT_W  acknowledged timeouts, wraps
- running  out  1  high whenever FSM is not IDLE
- error  out  1  sticky; spurious irq seen (status TO bit clear)

## Operation
- All outputs registered. Reset values: address 0, chipselect 0, write_n 1, writedata 0, tick 0, tick_count 0, running 0, error 0. FSM resets to IDLE.
- The master only issues accesses to addresses 0 (status) and 1 (control). It never writes 2 or 3, because period writes force a reload and stop the counter.
- IDLE: bus idle. enable=1 goes to CFG.
- CFG: one cycle of chipselect=1, write_n=0, address=1, writedata={12'b0,CTRL_START}. Next state is WAIT_IRQ.
- WAIT_IRQ: bus idle.
  - irq=1 goes to RD_ADDR.
  - Otherwise, enable=0 goes to STOP.
  - irq takes priority over enable=0.
- RD_ADDR: chipselect=1, write_n=1, address=0. Next state is RD_DATA.
- RD_DATA: bus idle; sample readdata.
  - readdata[0]=1 goes to CLR.
  - readdata[0]=0 sets error and returns to WAIT_IRQ. No clear write is issued.
- CLR: one cycle of chipselect=1, write_n=0, address=0, writedata=0.
  - tick=1 for this cycle.
  - tick_count increments, wrapping from all-ones to 0.
  - Next state is WAIT_IRQ.
- STOP: one cycle of write to address 1 with writedata={12'b0,CTRL_STOP}. Next state is IDLE.
- enable is sampled only in IDLE and WAIT_IRQ. An in-flight read/clear sequence always completes.
- tick_count and error are cleared only by reset. Re-enabling does not clear them.
- Reset mid-sequence: all outputs return to reset values immediately (async). No partial write is guaranteed. Software/bench must assume the timer state is unknown.

## Timing
- CFG is driven in the cycle after enable is first seen high in IDLE.
- irq first high in cycle N (WAIT_IRQ):
  - RD_ADDR in N+1.
  - RD_DATA in N+2.
  - CLR write and tick in N+3.
  - Back in WAIT_IRQ at N+4.
- irq deassertion: the slave clears TO on the edge ending CLR, so irq is low from N+4. No guard cycle is needed.
- If the timer times out during the CLR cycle, the status write wins and that timeout is lost. This is accepted; the minimum timer period is far larger than 4 cycles.
- Writes are single-cycle with no wait states; the slave has no waitrequest.

## Configuration
- AUDIO_TICK_STATUS_READ_EN defined: behaviour as above (read-verify before clear, error functional).
- AUDIO_TICK_STATUS_READ_EN undefined:
  - RD_ADDR and RD_DATA are removed; WAIT_IRQ with irq=1 goes directly to CLR.
  - tick is in cycle N+1 and WAIT_IRQ resumes at N+2.
  - error is tied 0.

## Test plan
- Reset asserted mid-CLR: bus returns to address 0, chipselect 0, write_n 1 at once; tick_count 0, running 0, error 0.
- enable 0→1 in IDLE: exactly one write, address 1, writedata 0x0007; running=1; bus then idle.
- irq high at cycle N with readdata 0x0003 in N+2: read address 0 in N+1; write address 0, data 0x0000 in N+3; tick pulse in N+3 only; tick_count=1.
- irq high with readdata 0x0002 in the RD_DATA cycle: error=1 and stays 1; no write to address 0; no tick; tick_count unchanged.
- 65536 acknowledged timeouts: tick_count wraps 0xFFFF→0x0000. Then enable→0 in WAIT_IRQ gives one write to address 1, data 0x0008, then IDLE with running=0.
- Macro undefined, irq high at N: write address 0, data 0 plus tick in N+1; no read cycle ever issued.
